// File: rtl/scan_sel_gen.sv
// Scan-select generator: a prescaler paces the 2-bit digit select w across the
// digits enabled in mask. The tick pulse marks each dwell expiry; valid tells
// downstream logic whether the selected digit should be lit.
module scan_sel_gen #(
  parameter int DIV   = 50000,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] mask,
  output logic [1:0] w,
  output logic       valid,
  output logic       tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] pcnt;
  logic             wrap;
  logic             found;
  logic [1:0]       idx;
  logic [1:0]       adv;
  logic [1:0]       w_next;

  // First enabled digit after w, searching w+1..w+3 and finally w itself.
  always_comb begin
    adv   = w;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = w + 2'(k);
      if (!found && mask[idx]) begin
        adv   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    wrap   = en && (pcnt == LAST);
    w_next = wrap ? adv : w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt  <= '0;
      w     <= '0;
      valid <= 1'b0;
      tick  <= 1'b0;
    end else begin
      pcnt  <= (!en || wrap) ? '0 : pcnt + CNT_W'(1);
      w     <= w_next;
      tick  <= wrap;
      // Valid follows the select being loaded, so it never lags w.
      valid <= en & mask[w_next];
    end
  end

endmodule
